// File: rtl/pipemem_bus_ctrl.sv
// pipemem_bus_ctrl
// MEM-stage controller sitting behind the EX/MEM pipeline register. A load
// or store becomes a req/ack transaction on the data-memory bus. The pipeline
// is stalled while the memory is busy. An access is aborted on a misaligned
// address or when the ack never arrives. The module also owns the MEM/WB
// register that feeds write-back.
//
// Ports
//   clk         clock, every state update happens on the rising edge
//   clrn        synchronous active-low reset
//   mwreg       EX/MEM: instruction writes the register file
//   mm2reg      EX/MEM: instruction is a load
//   mwmem       EX/MEM: instruction is a store
//   malu        EX/MEM: ALU result, also used as the memory address
//   mb          EX/MEM: store data
//   mrn         EX/MEM: destination register number
//   mem_req     bus request (combinational)
//   mem_we      bus direction, 1 = write
//   mem_addr    bus address
//   mem_wdata   bus write data
//   mem_ack     memory done; read data is valid in the same cycle
//   mem_rdata   bus read data
//   stall       freezes PC, IF/ID, ID/EX and EX/MEM (combinational)
//   wwreg       MEM/WB: register write enable
//   wm2reg      MEM/WB: select memory data
//   wmo         MEM/WB: loaded data
//   walu        MEM/WB: ALU result
//   wrn         MEM/WB: destination register
//   misalign    pulse: access whose address is not word aligned
//   bus_err     pulse: access aborted because the ack never arrived
//   err_sticky  set by misalign or bus_err, cleared only by reset
module pipemem_bus_ctrl #(
    parameter int DW       = 32,
    parameter int RW       = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mb,
    input  logic [RW-1:0] mrn,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [DW-1:0] wmo,
    output logic [DW-1:0] walu,
    output logic [RW-1:0] wrn,
    output logic          misalign,
    output logic          bus_err,
    output logic          err_sticky
);

    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   wcnt_reg;
    logic [CW-1:0]   wcnt_next;

    logic            access;
    logic            fault;
    logic            timeout;
    logic            load_done;

    // Reset gates the access term so that a request is withdrawn in the same
    // cycle that clrn falls, rather than one edge later.
    assign access    = clrn & (mwmem | mm2reg);
    assign fault     = access & (malu[1:0] != 2'b00);
    assign timeout   = (state_reg == WAIT) && (wcnt_reg == CW'(MAX_WAIT - 1));
    assign load_done = mm2reg & mem_req & mem_ack;

    // The bus mirrors the EX/MEM register directly; only req is qualified.
    assign mem_we    = mwmem;
    assign mem_addr  = malu;
    assign mem_wdata = mb;

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    // Next-state logic. wcnt holds the number of request cycles already spent
    // on the current access, so the first WAIT cycle sees wcnt == 1.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_next = WAIT;
                    wcnt_next  = CW'(1);
                end else begin
                    wcnt_next  = '0;
                end
            end
            WAIT: begin
                // An ack in the timeout cycle still completes normally.
                // A withdrawn request is treated as the end of the access so
                // the FSM can never sit in WAIT with nothing outstanding.
                if (!mem_req || mem_ack || timeout) begin
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next  = wcnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                wcnt_next  = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_req  = access & ~fault;
        // The timeout cycle itself does not stall: the instruction retires
        // (without a register write) on the following edge.
        stall    = mem_req & ~mem_ack & ~timeout;
        bus_err  = mem_req & timeout & ~mem_ack;
        misalign = fault;
    end

    // MEM/WB register and sticky error flag
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wwreg      <= 1'b0;
            wm2reg     <= 1'b0;
            wmo        <= '0;
            walu       <= '0;
            wrn        <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (stall) begin
                // Bubble: nothing may be written back while MEM is busy.
                wwreg  <= 1'b0;
                wm2reg <= 1'b0;
            end else begin
                wwreg  <= mwreg & ~fault & ~bus_err;
                wm2reg <= mm2reg;
                walu   <= malu;
                wrn    <= mrn;
                wmo    <= load_done ? mem_rdata : '0;
            end
            if (misalign || bus_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule
